chip8_seq_alu: RTL and testbench
================================

# chip8_seq_alu

Parametrised, handshaked successor to the Chip8 combinational ALU. Accepts one operation per transaction over a valid/ready input channel and returns a registered result, flag and error bit over a valid/ready output channel. Adds a multi-cycle binary-to-BCD operation for the Fx33 instruction. Sits between the CPU decode/execute FSM and the register file.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 4.
- BCD_DIGITS, 5: BCD digit count; requires 10^BCD_DIGITS > 2^WIDTH − 1.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- in_op  in  4  opcode: 0 NOP, 1 OR, 2 AND, 3 XOR, 4 ADD, 5 SUB, 6 LSHIFT, 7 RSHIFT, 8 EQ, 9 GT, 10 INC, 11 BCD, 12–15 undefined.
- in_a, in_b  in  WIDTH  operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  WIDTH  result.
- out_bcd  out  4*BCD_DIGITS  packed BCD, most significant digit in the top nibble; valid for op 11 only, zero otherwise.
- out_flag  out  1  carry / no-borrow / shifted-out bit.
- out_err  out  1  undefined opcode or disabled op.

## Operation
- FSM states: IDLE, BUSY (BCD iterating), DONE (holding result).
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational from out_ready.
- Accept = in_valid && in_ready. Operands and opcode are latched on accept.
- A single-cycle op goes to DONE. BCD goes to BUSY with iteration counter = WIDTH.
- BUSY performs one double-dabble step per cycle: add 3 to each digit ≥ 5, then shift left one bit. When the counter reaches 0, go to DONE.
- DONE holds all outputs stable until out_ready. On out_ready, go to IDLE, or take the next request directly if an accept occurs in the same cycle.
- Op semantics (flag = 0 unless stated):
  - NOP: result = a.
  - OR / AND / XOR: bitwise.
  - ADD: result = (a + b) mod 2^WIDTH; flag = carry out.
  - SUB: result = (a − b) mod 2^WIDTH; flag = (a ≥ b).
  - LSHIFT / RSHIFT: shift a by b. If 0 < b < WIDTH, flag = last bit shifted out. If b = 0, result = a and flag = 0. If b ≥ WIDTH, result = 0 and flag = 0.
  - EQ: result = (a == b).
  - GT: result = (a > b), unsigned.
  - INC: result = a + 1 wrapping; flag = 1 on wrap.
  - BCD: out_bcd = decimal digits of a; result = 0.
  - Undefined (12–15): result = 0, flag = 0, err = 1.
- Reset (asynchronous, any state, including mid-BCD): state IDLE, counter 0. out_valid, out_result, out_bcd, out_flag and out_err all 0. in_ready = 1 once reset_n is high.

## Timing
- Single-cycle op accepted at edge N: out_valid and outputs are visible after edge N (1-cycle latency).
- BCD accepted at edge N: out_valid is visible after edge N+WIDTH (WIDTH-cycle latency).
- Throughput is one single-cycle op per cycle while out_ready is held high.
- out_valid never drops without out_ready. Outputs do not change while out_valid && !out_ready.
- in_valid while BUSY, or while DONE with out_ready low: the request is not accepted and the requester must hold it.

## Configuration
- CHIP8_ALU_BCD_EN defined: BCD op, BUSY state and double-dabble datapath are compiled in, as described above.
- Not defined: no BUSY state and no BCD datapath; the out_bcd port is kept and tied to 0. Opcode 11 completes in one cycle with result 0, flag 0, err 1, handled exactly like an undefined opcode.

## Test plan
- ADD with WIDTH=16: a=16'hC000, b=16'hC000 → result 16'h8000, flag 1, err 0, out_valid one cycle after accept.
- SUB then GT, back-to-back with out_ready held high: SUB a=16'hE0A5, b=16'h7003 → result 16'h70A2, flag 1. Next cycle GT a=16'h0832, b=16'h8832 → result 0. in_ready stays high throughout.
- Shifts: LSHIFT a=16'h4F00, b=4 → result 16'hF000, flag 0. RSHIFT a=16'h0031, b=2 → result 16'h000C, flag 0. LSHIFT with b=16 → result 0, flag 0.
- BCD (macro defined): a=16'd65535 → out_bcd 20'h65535 exactly 16 cycles after accept. A second request during BUSY sees in_ready = 0. With out_ready held low for 5 cycles, outputs stay stable.
- Reset_n pulsed low mid-BCD (iteration 7) → out_valid drops to 0 immediately and all outputs are 0. After release, INC a=16'hFFFF → result 0, flag 1.
- Opcode 13, and opcode 11 with the macro undefined → result 0, flag 0, err 1, 1-cycle latency.

Source files
------------

// File: rtl/chip8_seq_alu.sv
// chip8_seq_alu
// Handshaked, registered successor to the Chip8 combinational ALU. One
// operation is accepted per transaction on the in_* valid/ready channel; the
// registered result, flag and error bit are returned on the out_* channel.
//
// Build option: define CHIP8_ALU_BCD_EN to compile in the multi-cycle
// binary-to-BCD operation (opcode 11, Fx33). Without it, opcode 11 is treated
// as an undefined opcode and out_bcd is tied to zero.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   operation request
//   in_ready   out  request can be accepted (combinational from out_ready)
//   in_op      in   4-bit opcode
//   in_a/in_b  in   WIDTH-bit operands
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   out_result out  WIDTH-bit result
//   out_bcd    out  packed BCD, most significant digit in the top nibble
//   out_flag   out  carry / no-borrow / shifted-out bit
//   out_err    out  undefined or disabled opcode
module chip8_seq_alu #(
  parameter int WIDTH      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_op,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_result,
  output logic [4*BCD_DIGITS-1:0] out_bcd,
  output logic                    out_flag,
  output logic                    out_err
);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_OR     = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_XOR    = 4'd3;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd5;
  localparam logic [3:0] OP_LSHIFT = 4'd6;
  localparam logic [3:0] OP_RSHIFT = 4'd7;
  localparam logic [3:0] OP_EQ     = 4'd8;
  localparam logic [3:0] OP_GT     = 4'd9;
  localparam logic [3:0] OP_INC    = 4'd10;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

`ifdef CHIP8_ALU_BCD_EN
  localparam logic [3:0] OP_BCD = 4'd11;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DD_W  = 4*BCD_DIGITS + WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic                    flag_q, flag_d;
  logic                    err_q, err_d;
  logic                    accept;

  logic [WIDTH-1:0]        alu_res;
  logic                    alu_flag;
  logic                    alu_err;
  logic [WIDTH:0]          wide;

`ifdef CHIP8_ALU_BCD_EN
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*BCD_DIGITS-1:0] adj;
  logic [DD_W-1:0]         dd;
`endif

  // Single-cycle datapath, evaluated on the raw inputs so the result can be
  // registered on the accepting edge. Shifts use a one-bit-wider vector so
  // the last bit shifted out lands in a fixed position.
  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    alu_err  = 1'b0;
    wide     = '0;
    case (in_op)
      OP_NOP: alu_res = in_a;
      OP_OR:  alu_res = in_a | in_b;
      OP_AND: alu_res = in_a & in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_ADD: begin
        wide     = {1'b0, in_a} + {1'b0, in_b};
        alu_res  = wide[WIDTH-1:0];
        alu_flag = wide[WIDTH];
      end
      OP_SUB: begin
        alu_res  = in_a - in_b;
        alu_flag = (in_a >= in_b);
      end
      OP_LSHIFT: begin
        if (in_b < WIDTH_V) begin
          wide     = {1'b0, in_a} << in_b;
          alu_res  = wide[WIDTH-1:0];
          alu_flag = wide[WIDTH];
        end
      end
      OP_RSHIFT: begin
        if (in_b < WIDTH_V) begin
          wide     = {in_a, 1'b0} >> in_b;
          alu_res  = wide[WIDTH:1];
          alu_flag = wide[0];
        end
      end
      OP_EQ: alu_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      OP_GT: alu_res = {{(WIDTH-1){1'b0}}, (in_a > in_b)};
      OP_INC: begin
        wide     = {1'b0, in_a} + (WIDTH+1)'(1);
        alu_res  = wide[WIDTH-1:0];
        alu_flag = wide[WIDTH];
      end
`ifdef CHIP8_ALU_BCD_EN
      // The operand seeds the binary shift register; after WIDTH shifts it
      // has drained to zero, which is exactly the required BCD result.
      OP_BCD: alu_res = in_a;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef CHIP8_ALU_BCD_EN
  // One double-dabble step: correct every digit >= 5 by adding 3, then shift
  // the combined {bcd, binary} register left by one bit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    dd = {adj, result_q} << 1;
  end
`endif

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state logic: DONE releases on out_ready and may chain straight into
  // the next accepted request without passing through IDLE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
`ifdef CHIP8_ALU_BCD_EN
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
`ifdef CHIP8_ALU_BCD_EN
      BUSY: begin
        bcd_d    = dd[DD_W-1:WIDTH];
        result_d = dd[WIDTH-1:0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
`endif
      default: begin
        if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
        if (accept) begin
          result_d = alu_res;
          flag_d   = alu_flag;
          err_d    = alu_err;
          state_d  = DONE;
`ifdef CHIP8_ALU_BCD_EN
          bcd_d    = '0;
          if (in_op == OP_BCD) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WIDTH);
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CHIP8_ALU_BCD_EN
      bcd_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
`ifdef CHIP8_ALU_BCD_EN
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flag   = flag_q;
  assign out_err    = err_q;
`ifdef CHIP8_ALU_BCD_EN
  assign out_bcd    = bcd_q;
`else
  assign out_bcd    = '0;
`endif

endmodule

// File: tb/tb_chip8_seq_alu.sv
// tb_chip8_seq_alu
// Self-checking bench for chip8_seq_alu (WIDTH=16, BCD_DIGITS=5). A table of
// single-cycle vectors is streamed back-to-back, followed by hand-written
// sequences for backpressure, the BCD operation (when CHIP8_ALU_BCD_EN is
// defined) and asynchronous reset.
module tb_chip8_seq_alu;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [19:0] out_bcd;
  logic        out_flag;
  logic        out_err;

  int assertCount;
  int failCount;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        flag;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  chip8_seq_alu #(.WIDTH(16), .BCD_DIGITS(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_bcd    (out_bcd),
    .out_flag   (out_flag),
    .out_err    (out_err)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] r,
                                 input logic f, input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.result = r; v.flag = f; v.err = e;
    return v;
  endfunction

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive a request at the falling edge, record in_ready just before the
  // rising edge, and return 1ns after that rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, output logic readySeen);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1 readySeen = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"},  32'(out_valid),  32'h0);
    checkOutput({tag, ".result"}, 32'(out_result), 32'h0);
    checkOutput({tag, ".bcd"},    32'(out_bcd),    32'h0);
    checkOutput({tag, ".flag"},   32'(out_flag),   32'h0);
    checkOutput({tag, ".err"},    32'(out_err),    32'h0);
  endtask

  initial begin
    logic rdy;
    int   cyc;
    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_op       = 4'd0;
    in_a        = 16'h0;
    in_b        = 16'h0;
    out_ready   = 1'b1;

    // Single-cycle vectors with hand-computed results.
    vecs.push_back(mkVec(4'd4,  16'hC000, 16'hC000, 16'h8000, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd5,  16'hE0A5, 16'h7003, 16'h70A2, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd9,  16'h0832, 16'h8832, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd6,  16'h4F00, 16'd4,    16'hF000, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd7,  16'h0031, 16'd2,    16'h000C, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd6,  16'h4F00, 16'd16,   16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd0,  16'hABCD, 16'h1111, 16'hABCD, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd1,  16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd2,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd3,  16'hFFFF, 16'h1234, 16'hEDCB, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd8,  16'h5555, 16'h5555, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd8,  16'h5555, 16'h5556, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd9,  16'h8832, 16'h0832, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd5,  16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd5,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd10, 16'h0041, 16'h0000, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd10, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd7,  16'h8001, 16'd1,    16'h4000, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd6,  16'h8001, 16'd1,    16'h0002, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd6,  16'h1234, 16'd0,    16'h1234, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd7,  16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd7,  16'hFFFF, 16'd20,   16'h0000, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd4,  16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0));
    vecs.push_back(mkVec(4'd4,  16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0));
    vecs.push_back(mkVec(4'd13, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mkVec(4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mkVec(4'd15, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b1));
`ifndef CHIP8_ALU_BCD_EN
    vecs.push_back(mkVec(4'd11, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1));
`endif

    // Reset state while reset_n is held low, then in_ready after release.
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1 checkOutput("reset.in_ready", 32'(in_ready), 32'h1);

    // Stream the table back-to-back with out_ready held high.
    $display("[TB] streaming %0d single-cycle vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, rdy);
      checkOutput($sformatf("vec%0d.in_ready", i), 32'(rdy), 32'h1);
      checkOutput($sformatf("vec%0d.valid", i),  32'(out_valid),  32'h1);
      checkOutput($sformatf("vec%0d.result", i), 32'(out_result), 32'(vecs[i].result));
      checkOutput($sformatf("vec%0d.flag", i),   32'(out_flag),   32'(vecs[i].flag));
      checkOutput($sformatf("vec%0d.err", i),    32'(out_err),    32'(vecs[i].err));
      checkOutput($sformatf("vec%0d.bcd", i),    32'(out_bcd),    32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 checkOutput("drain.valid", 32'(out_valid), 32'h0);

    // Backpressure: result held while out_ready is low, the pending request
    // waits and is taken on the same edge that releases the result.
    $display("[TB] backpressure sequence");
    out_ready = 1'b0;
    applyStimulus(4'd4, 16'h1111, 16'h2222, rdy);
    checkOutput("bp.accept_ready", 32'(rdy), 32'h1);
    @(negedge clk);
    in_op = 4'd3; in_a = 16'hFFFF; in_b = 16'h00FF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp.hold%0d.valid", k),  32'(out_valid),  32'h1);
      checkOutput($sformatf("bp.hold%0d.result", k), 32'(out_result), 32'h3333);
      checkOutput($sformatf("bp.hold%0d.ready", k),  32'(in_ready),   32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 checkOutput("bp.release_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("bp.next.valid",  32'(out_valid),  32'h1);
    checkOutput("bp.next.result", 32'(out_result), 32'hFF00);
    checkOutput("bp.next.flag",   32'(out_flag),   32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 checkOutput("bp.idle.valid", 32'(out_valid), 32'h0);

`ifdef CHIP8_ALU_BCD_EN
    // BCD of 65535: exact 16-cycle latency, in_ready low while busy, and a
    // stable result under 5 cycles of backpressure.
    $display("[TB] BCD sequence");
    out_ready = 1'b0;
    applyStimulus(4'd11, 16'd65535, 16'h0000, rdy);
    checkOutput("bcd.accept_ready", 32'(rdy), 32'h1);
    checkOutput("bcd.busy_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_op = 4'd4; in_a = 16'h0001; in_b = 16'h0002;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) checkOutput("bcd.busy_ready", 32'(in_ready), 32'h0);
    end
    checkOutput("bcd.latency", 32'(cyc), 32'd16);
    checkOutput("bcd.bcd",    32'(out_bcd),    32'h65535);
    checkOutput("bcd.result", 32'(out_result), 32'h0);
    checkOutput("bcd.flag",   32'(out_flag),   32'h0);
    checkOutput("bcd.err",    32'(out_err),    32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bcd.hold%0d.valid", k), 32'(out_valid), 32'h1);
      checkOutput($sformatf("bcd.hold%0d.bcd", k),   32'(out_bcd),   32'h65535);
      checkOutput($sformatf("bcd.hold%0d.ready", k), 32'(in_ready),  32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bcd.next.result", 32'(out_result), 32'h0003);
    checkOutput("bcd.next.bcd",    32'(out_bcd),    32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a BCD conversion.
    $display("[TB] reset during BCD");
    out_ready = 1'b0;
    applyStimulus(4'd11, 16'd12345, 16'h0000, rdy);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 checkOutput("rst.busy_valid", 32'(out_valid), 32'h0);
`else
    // Asynchronous reset while a result is being held.
    $display("[TB] reset during held result");
    out_ready = 1'b0;
    applyStimulus(4'd4, 16'h00FF, 16'h0F01, rdy);
    checkOutput("rst.held.result", 32'(out_result), 32'h1000);
    @(negedge clk);
    in_valid = 1'b0;
`endif
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checkAllZero("rst");
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.release_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    applyStimulus(4'd10, 16'hFFFF, 16'h0000, rdy);
    checkOutput("rst.inc.ready",  32'(rdy),        32'h1);
    checkOutput("rst.inc.valid",  32'(out_valid),  32'h1);
    checkOutput("rst.inc.result", 32'(out_result), 32'h0000);
    checkOutput("rst.inc.flag",   32'(out_flag),   32'h1);
    checkOutput("rst.inc.err",    32'(out_err),    32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
